// File: rtl/vga_timing_gen_pkg.sv
// Shared video-mode definitions for the VGA timing generator: mode tables,
// coordinate widths, sync polarities and the raster region decode helper.
package vga_timing_gen_pkg;

  // Coordinate port widths, sized for the largest supported mode (640x480).
  localparam int X_COORD_WIDTH = 10;
  localparam int Y_COORD_WIDTH = 9;

  localparam logic SYNC_POL_NEG = 1'b0;
  localparam logic SYNC_POL_POS = 1'b1;

  // One axis of a video mode, in clocks (horizontal) or lines (vertical).
  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
  } axis_timing_t;

  // Order of regions inside a line or a frame.
  typedef enum logic [1:0] {
    REGION_ACTIVE = 2'd0,
    REGION_FP     = 2'd1,
    REGION_SYNC   = 2'd2,
    REGION_BP     = 2'd3
  } region_e;

  // 640x480 @ 72 Hz, 31.5 MHz pixel clock (default mode).
  localparam axis_timing_t MODE_640X480_72_H = '{active: 640, fp: 24, sync: 40, bp: 128};
  localparam axis_timing_t MODE_640X480_72_V = '{active: 480, fp: 9,  sync: 3,  bp: 28};
  localparam logic         MODE_640X480_72_HPOL = SYNC_POL_NEG;
  localparam logic         MODE_640X480_72_VPOL = SYNC_POL_NEG;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock.
  localparam axis_timing_t MODE_640X480_60_H = '{active: 640, fp: 16, sync: 96, bp: 48};
  localparam axis_timing_t MODE_640X480_60_V = '{active: 480, fp: 10, sync: 2,  bp: 33};
  localparam logic         MODE_640X480_60_HPOL = SYNC_POL_NEG;
  localparam logic         MODE_640X480_60_VPOL = SYNC_POL_NEG;

  function automatic int axis_total(input axis_timing_t t);
    return t.active + t.fp + t.sync + t.bp;
  endfunction

  localparam int H_TOTAL = axis_total(MODE_640X480_72_H);
  localparam int V_TOTAL = axis_total(MODE_640X480_72_V);

  // Classify a counter value into its region of the line/frame.
  function automatic region_e region_of(input int cnt, input int active, input int fp,
                                        input int sync);
    if (cnt < active) begin
      return REGION_ACTIVE;
    end else if (cnt < active + fp) begin
      return REGION_FP;
    end else if (cnt < active + fp + sync) begin
      return REGION_SYNC;
    end
    return REGION_BP;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register that delays a sync signal; every stage resets
// asynchronously to the sync's inactive level.
module vga_sync_delay #(
  parameter int   DEPTH     = 2,
  parameter logic RST_LEVEL = 1'b1
) (
  input  logic px_clk,
  input  logic reset,
  input  logic sync_in,
  output logic sync_out
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = px_clk ^ reset;
      assign sync_out = sync_in;
    end else begin : g_pipe
      logic [DEPTH-1:0] stage_reg;

      always_ff @(posedge px_clk or negedge reset) begin
        if (!reset) begin
          stage_reg <= {DEPTH{RST_LEVEL}};
        end else begin
          stage_reg[0] <= sync_in;
          for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
          end
        end
      end

      assign sync_out = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: counters, registered coordinate/sync decode and sync delay line.
// Optional 16-bit frame counter output when VGA_TIMING_FRAME_COUNT_EN is defined.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   H_ACTIVE   = MODE_640X480_72_H.active,
  parameter int   H_FP       = MODE_640X480_72_H.fp,
  parameter int   H_SYNC     = MODE_640X480_72_H.sync,
  parameter int   H_BP       = MODE_640X480_72_H.bp,
  parameter int   V_ACTIVE   = MODE_640X480_72_V.active,
  parameter int   V_FP       = MODE_640X480_72_V.fp,
  parameter int   V_SYNC     = MODE_640X480_72_V.sync,
  parameter int   V_BP       = MODE_640X480_72_V.bp,
  parameter logic H_POL      = MODE_640X480_72_HPOL,
  parameter logic V_POL      = MODE_640X480_72_VPOL,
  parameter int   SYNC_DELAY = 2
) (
  input  logic                     px_clk,
  input  logic                     reset,
`ifdef VGA_TIMING_FRAME_COUNT_EN
  output logic [15:0]              frame_count,
`endif
  output logic [X_COORD_WIDTH-1:0] x_px,
  output logic [Y_COORD_WIDTH-1:0] y_px,
  output logic                     activevideo,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);

  generate
    if (H_FP <= 0 || H_SYNC <= 0 || H_BP <= 0 || V_FP <= 0 || V_SYNC <= 0 || V_BP <= 0)
    begin : g_err_porch
      $error("vga_timing_gen: porch and sync widths must be non-zero");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_err_delay
      $error("vga_timing_gen: SYNC_DELAY must be in 0..7");
    end
    if (H_ACTIVE > (1 << X_COORD_WIDTH)) begin : g_err_xw
      $error("vga_timing_gen: H_ACTIVE exceeds X_COORD_WIDTH range");
    end
    if (V_ACTIVE > (1 << Y_COORD_WIDTH)) begin : g_err_yw
      $error("vga_timing_gen: V_ACTIVE exceeds Y_COORD_WIDTH range");
    end
  endgenerate

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;
  logic          h_wrap;
  logic          v_wrap;

  assign h_wrap = (h_cnt_reg == H_LAST);
  assign v_wrap = (v_cnt_reg == V_LAST);

  // v_cnt advances only on the h_cnt wrap edge, so a combined line/frame wrap
  // returns both counters to 0 on a single edge.
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_wrap) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= v_wrap ? '0 : v_cnt_reg + VW'(1);
    end else begin
      h_cnt_reg <= h_cnt_reg + HW'(1);
    end
  end

  region_e h_region;
  region_e v_region;
  logic    pix_active;
  logic    raster_origin;

  always_comb begin
    h_region      = region_of(int'(h_cnt_reg), H_ACTIVE, H_FP, H_SYNC);
    v_region      = region_of(int'(v_cnt_reg), V_ACTIVE, V_FP, V_SYNC);
    pix_active    = (h_region == REGION_ACTIVE) && (v_region == REGION_ACTIVE);
    raster_origin = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  end

  logic hsync_raw_reg;
  logic vsync_raw_reg;

  // Decode stage: everything here is one clock behind the counters.
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      x_px          <= '0;
      y_px          <= '0;
      activevideo   <= 1'b0;
      frame_start   <= 1'b0;
      hsync_raw_reg <= ~H_POL;
      vsync_raw_reg <= ~V_POL;
    end else begin
      activevideo   <= pix_active;
      x_px          <= pix_active ? X_COORD_WIDTH'(h_cnt_reg) : '0;
      y_px          <= pix_active ? Y_COORD_WIDTH'(v_cnt_reg) : '0;
      frame_start   <= raster_origin;
      hsync_raw_reg <= (h_region == REGION_SYNC) ? H_POL : ~H_POL;
      vsync_raw_reg <= (v_region == REGION_SYNC) ? V_POL : ~V_POL;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  always_ff @(posedge px_clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (raster_origin) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

  // Syncs trail the decode by SYNC_DELAY stages to line up with the renderer's pixels.
  vga_sync_delay #(
    .DEPTH     (SYNC_DELAY),
    .RST_LEVEL (~H_POL)
  ) u_hsync_delay (
    .px_clk   (px_clk),
    .reset    (reset),
    .sync_in  (hsync_raw_reg),
    .sync_out (hsync)
  );

  vga_sync_delay #(
    .DEPTH     (SYNC_DELAY),
    .RST_LEVEL (~V_POL)
  ) u_vsync_delay (
    .px_clk   (px_clk),
    .reset    (reset),
    .sync_in  (vsync_raw_reg),
    .sync_out (vsync)
  );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen on a scaled-down mode (25 x 10 raster)
// so several whole frames fit in a short run.
module tb_vga_timing_gen;
  import vga_timing_gen_pkg::*;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 4;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 1;
  localparam int SD = 2;
  localparam int HT = HA + HFP + HS + HBP;   // 25
  localparam int VT = VA + VFP + VS + VBP;   // 10
  localparam int FRAME = HT * VT;            // 250

  logic                     px_clk;
  logic                     reset;
  logic [X_COORD_WIDTH-1:0] x_px;
  logic [Y_COORD_WIDTH-1:0] y_px;
  logic                     activevideo, hsync, vsync, frame_start;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0]              frame_count;
`endif

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .H_POL(1'b0), .V_POL(1'b0), .SYNC_DELAY(SD)
  ) dut (
    .px_clk      (px_clk),
    .reset       (reset),
`ifdef VGA_TIMING_FRAME_COUNT_EN
    .frame_count (frame_count),
`endif
    .x_px        (x_px),
    .y_px        (y_px),
    .activevideo (activevideo),
    .hsync       (hsync),
    .vsync       (vsync),
    .frame_start (frame_start)
  );

  initial begin
    px_clk = 1'b0;
    forever #5 px_clk = ~px_clk;
  end

  typedef struct {
    int                       k;
    logic [X_COORD_WIDTH-1:0] x;
    logic [Y_COORD_WIDTH-1:0] y;
    logic                     av, fs, hs, vs;
  } vec_t;

  int   tests_run;
  int   tests_failed;
  int   k;              // rising edges since the last reset release
  vec_t tbl[16];

  // Stats gathered over the first long run
  int hs_low_f0, vs_low_f0, av_f0, last_fall, hs_run;
  logic prev_hs;

  function automatic vec_t mk(input int kk, input int x, input int y, input logic av,
                              input logic fs, input logic hs, input logic vs);
    vec_t v;
    v.k = kk; v.x = x[X_COORD_WIDTH-1:0]; v.y = y[Y_COORD_WIDTH-1:0];
    v.av = av; v.fs = fs; v.hs = hs; v.vs = vs;
    return v;
  endfunction

  // Reference: edge k shows the decode of raster position k-1; syncs show position k-1-SD.
  function automatic vec_t model_at(input int kk);
    vec_t e;
    int p, q, hx, vy;
    e = mk(kk, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1);
    if (kk >= 1) begin
      p  = (kk - 1) % FRAME;
      hx = p % HT;
      vy = p / HT;
      if (hx < HA && vy < VA) begin
        e.av = 1'b1;
        e.x  = hx[X_COORD_WIDTH-1:0];
        e.y  = vy[Y_COORD_WIDTH-1:0];
      end
      e.fs = (p == 0);
    end
    if (kk - 1 - SD >= 0) begin
      q  = (kk - 1 - SD) % FRAME;
      hx = q % HT;
      vy = q / HT;
      e.hs = !(hx >= HA + HFP && hx < HA + HFP + HS);
      e.vs = !(vy >= VA + VFP && vy < VA + VFP + VS);
    end
    return e;
  endfunction

  task automatic compare_vec(input string tag, input vec_t e);
    tests_run++;
    if (x_px !== e.x || y_px !== e.y || activevideo !== e.av || frame_start !== e.fs ||
        hsync !== e.hs || vsync !== e.vs) begin
      tests_failed++;
      $display("FAIL %s k=%0d got x=%0d y=%0d av=%b fs=%b hs=%b vs=%b exp x=%0d y=%0d av=%b fs=%b hs=%b vs=%b",
               tag, e.k, x_px, y_px, activevideo, frame_start, hsync, vsync,
               e.x, e.y, e.av, e.fs, e.hs, e.vs);
    end
  endtask

  task automatic compare_int(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("[TB] %s ok (%0d)", tag, got);
    end
  endtask

  task automatic run_cycles(input int n, input bit with_stats);
    vec_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge px_clk);
      k++;
      @(negedge px_clk);
      e = model_at(k);
      compare_vec("model", e);
      if (with_stats) begin
        for (int j = 0; j < 16; j++) begin
          if (tbl[j].k == k) compare_vec("vector", tbl[j]);
        end
        if (k <= FRAME) begin
          if (!hsync) hs_low_f0++;
          if (!vsync) vs_low_f0++;
          if (activevideo) av_f0++;
        end
        if (prev_hs && !hsync) begin
          if (last_fall == 0) compare_int("hs_fall_offset", k - 1, HA + HFP + SD);
          else compare_int("hs_period", k - last_fall, HT);
          last_fall = k;
          hs_run = 0;
        end
        if (!hsync) hs_run++;
        if (!prev_hs && hsync && last_fall != 0) compare_int("hs_width", hs_run, HS);
        prev_hs = hsync;
      end
    end
  endtask

  task automatic release_reset();
    @(negedge px_clk);
    reset = 1'b1;
    k = 0;
  endtask

  initial begin
    vec_t e;
    int n, d, hold;
    tests_run = 0; tests_failed = 0; k = 0;
    hs_low_f0 = 0; vs_low_f0 = 0; av_f0 = 0; last_fall = 0; hs_run = 0; prev_hs = 1'b1;

    tbl[0]  = mk(1,   0,  0, 1, 1, 1, 1);
    tbl[1]  = mk(16,  15, 0, 1, 0, 1, 1);
    tbl[2]  = mk(17,  0,  0, 0, 0, 1, 1);
    tbl[3]  = mk(20,  0,  0, 0, 0, 1, 1);
    tbl[4]  = mk(21,  0,  0, 0, 0, 0, 1);
    tbl[5]  = mk(23,  0,  0, 0, 0, 0, 1);
    tbl[6]  = mk(24,  0,  0, 0, 0, 1, 1);
    tbl[7]  = mk(26,  0,  1, 1, 0, 1, 1);
    tbl[8]  = mk(141, 15, 5, 1, 0, 1, 1);
    tbl[9]  = mk(150, 0,  0, 0, 0, 1, 1);
    tbl[10] = mk(177, 0,  0, 0, 0, 1, 1);
    tbl[11] = mk(178, 0,  0, 0, 0, 1, 0);
    tbl[12] = mk(227, 0,  0, 0, 0, 1, 0);
    tbl[13] = mk(228, 0,  0, 0, 0, 1, 1);
    tbl[14] = mk(251, 0,  0, 1, 1, 1, 1);
    tbl[15] = mk(252, 1,  0, 1, 0, 1, 1);

    // Reset held for 10 clocks
    reset = 1'b0;
    repeat (10) @(negedge px_clk);
    compare_vec("reset_hold", model_at(0));
    reset = 1'b1;
    k = 0;
    #1 compare_vec("pre_first_edge", model_at(0));

    // Two full frames plus the wrap into the third
    run_cycles(2 * FRAME + 1, 1'b1);
    compare_int("hs_low_per_frame", hs_low_f0, HS * VT);
    compare_int("vs_low_per_frame", vs_low_f0, VS * HT);
    compare_int("active_per_frame", av_f0, HA * VA);
`ifdef VGA_TIMING_FRAME_COUNT_EN
    compare_int("frame_count", int'(frame_count), 3);
`endif

    // Asynchronous reset at h=10, v=3, between clock edges
    reset = 1'b0;
    repeat (2) @(negedge px_clk);
    release_reset();
    run_cycles(3 * HT + 10, 1'b0);
    #2 reset = 1'b0;
    #1 compare_vec("async_mid_frame", model_at(0));
    repeat (3) @(negedge px_clk);
    compare_vec("async_hold", model_at(0));
    release_reset();
    run_cycles(1, 1'b0);
    compare_vec("restart_origin", mk(1, 0, 0, 1, 1, 1, 1));
`ifdef VGA_TIMING_FRAME_COUNT_EN
    compare_int("frame_count_restart", int'(frame_count), 1);
`endif
    run_cycles(HT + 5, 1'b0);

    // Randomized reset pulses at random points of the raster
    for (int it = 0; it < 6; it++) begin
      n    = $urandom_range(1, 2 * FRAME);
      d    = $urandom_range(1, 8);
      hold = $urandom_range(1, 5);
      run_cycles(n, 1'b0);
      @(posedge px_clk);
      #(d) reset = 1'b0;
      #1 compare_vec("rand_async_reset", model_at(0));
      repeat (hold) @(negedge px_clk);
      release_reset();
      run_cycles(HT + 3, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
